// File: rtl/player_hp_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : player_hp_ctrl                                              |
// | Purpose  : player health FSM with hit damage, frame-counted            |
// |            invulnerability with sprite blink, death and restart.       |
// | Options  : HP_REGEN_EN - periodic +1 HP regeneration while ALIVE       |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module player_hp_ctrl #(
  parameter int HP_MAX        = 9,
  parameter int INVULN_FRAMES = 60,
  parameter int BLINK_SHIFT   = 2,
  parameter int REGEN_FRAMES  = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vblnk,
  input  logic       start,
  input  logic       hit,
  input  logic [3:0] dmg,
  output logic [3:0] hp_out,
  output logic       dead,
  output logic       invuln,
  output logic       blink
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ALIVE  = 2'd1,
    S_INVULN = 2'd2,
    S_DEAD   = 2'd3
  } state_t;

  // Counter must be wide enough for the load value and for the blink bit tap.
  localparam int C_INV_W_MIN = $clog2(INVULN_FRAMES + 1);
  localparam int C_INV_W     = (C_INV_W_MIN > BLINK_SHIFT) ? C_INV_W_MIN : BLINK_SHIFT + 1;

  localparam logic [3:0]         C_HP_MAX   = 4'(HP_MAX);
  localparam logic [C_INV_W-1:0] C_INV_LOAD = C_INV_W'(INVULN_FRAMES);
  localparam logic [C_INV_W-1:0] C_INV_ONE  = C_INV_W'(1);

  generate
    if (HP_MAX < 1 || HP_MAX > 9 || INVULN_FRAMES < 1 || REGEN_FRAMES < 1 || BLINK_SHIFT < 0)
    begin : g_param_check
      $error("player_hp_ctrl: illegal parameter value");
    end
  endgenerate

  state_t             r_state;
  logic               r_vblnk_q;
  logic [C_INV_W-1:0] r_inv_cnt;
  logic               w_tick;
  logic [C_INV_W-1:0] w_inv_dec;

`ifdef HP_REGEN_EN
  localparam int                   C_REGEN_W    = $clog2(REGEN_FRAMES + 1);
  localparam logic [C_REGEN_W-1:0] C_REGEN_LAST = C_REGEN_W'(REGEN_FRAMES - 1);
  localparam logic [C_REGEN_W-1:0] C_REGEN_ONE  = C_REGEN_W'(1);

  logic [C_REGEN_W-1:0] r_regen_cnt;
`endif

  assign w_tick    = vblnk & ~r_vblnk_q;
  assign w_inv_dec = r_inv_cnt - C_INV_ONE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_vblnk_q <= 1'b0;
      r_inv_cnt <= '0;
      hp_out    <= C_HP_MAX;
      dead      <= 1'b0;
      invuln    <= 1'b0;
      blink     <= 1'b0;
`ifdef HP_REGEN_EN
      r_regen_cnt <= '0;
`endif
    end else begin
      r_vblnk_q <= vblnk;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_ALIVE;
            hp_out  <= C_HP_MAX;
`ifdef HP_REGEN_EN
            r_regen_cnt <= '0;
`endif
          end
        end

        S_ALIVE: begin
          // A damaging hit takes priority over any tick arriving the same cycle.
          if (hit && (dmg != 4'd0)) begin
`ifdef HP_REGEN_EN
            r_regen_cnt <= '0;
`endif
            if (dmg >= hp_out) begin
              r_state <= S_DEAD;
              hp_out  <= 4'd0;
              dead    <= 1'b1;
            end else begin
              r_state   <= S_INVULN;
              hp_out    <= hp_out - dmg;
              invuln    <= 1'b1;
              r_inv_cnt <= C_INV_LOAD;
              blink     <= C_INV_LOAD[BLINK_SHIFT];
            end
          end
`ifdef HP_REGEN_EN
          else if (w_tick) begin
            if (r_regen_cnt == C_REGEN_LAST) begin
              r_regen_cnt <= '0;
              if (hp_out < C_HP_MAX) begin
                hp_out <= hp_out + 4'd1;
              end
            end else begin
              r_regen_cnt <= r_regen_cnt + C_REGEN_ONE;
            end
          end
`endif
        end

        S_INVULN: begin
          if (w_tick) begin
            if (r_inv_cnt == C_INV_ONE) begin
              r_state   <= S_ALIVE;
              r_inv_cnt <= '0;
              invuln    <= 1'b0;
              blink     <= 1'b0;
            end else begin
              r_inv_cnt <= w_inv_dec;
              blink     <= w_inv_dec[BLINK_SHIFT];
            end
          end
        end

        S_DEAD: begin
          if (start) begin
            r_state <= S_ALIVE;
            hp_out  <= C_HP_MAX;
            dead    <= 1'b0;
`ifdef HP_REGEN_EN
            r_regen_cnt <= '0;
`endif
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/player_hp_ctrl.md
Name: player_hp_ctrl

Overview:
- Player health controller. Sits directly upstream of the in-game HUD text stage and drives its 4-bit HP value, which is rendered as "HP n".
- Takes hit events from collision logic and applies damage. Provides a frame-counted invulnerability window after each hit, with a blink flag for the sprite stage.
- Flags death and restarts on a start request.

Parameters:
- HP_MAX, 9, starting and maximum HP. Legal range is 1..9 because the HUD shows a single digit.
- INVULN_FRAMES, 60, number of frames of invulnerability after a non-lethal hit (≥1).
- BLINK_SHIFT, 2, bit of the invulnerability frame counter used for blink; it toggles every 2^BLINK_SHIFT frames.
- REGEN_FRAMES, 300, frames per +1 HP regeneration. Used only with HP_REGEN_EN.

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous active-low reset
- vblnk  in  1  vertical blank from the timing chain; its rising edge marks a frame tick
- start  in  1  single-cycle game start/restart request
- hit  in  1  single-cycle hit strobe from collision detection
- dmg  in  4  damage carried by hit; sampled only when hit=1
- hp_out  out  4  current HP, 0..HP_MAX, feeds the HUD stage
- dead  out  1  high while in DEAD
- invuln  out  1  high while in INVULN
- blink  out  1  sprite-hide flag; meaningful only when invuln=1, otherwise 0

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, hp_out=HP_MAX, dead=0, invuln=0, blink=0, all counters=0, vblnk_q=0.
- All outputs are registered. An accepted event is visible on outputs in the cycle after it is sampled (latency 1).
- Frame tick: vblnk is registered into vblnk_q; tick = vblnk & ~vblnk_q, one cycle wide.
- States:
  - IDLE: hp_out=HP_MAX. hit is ignored. start -> ALIVE.
  - ALIVE: start is ignored. On hit with dmg==0, no effect. On hit with dmg>0:
    - hp_next = (dmg >= hp) ? 0 : hp - dmg, with saturating 4-bit compare.
    - hp_next==0 -> DEAD.
    - Otherwise -> INVULN, inv_cnt loaded with INVULN_FRAMES.
  - INVULN: hit and start are ignored. Each tick decrements inv_cnt; a tick while inv_cnt==1 -> ALIVE with inv_cnt=0. blink = inv_cnt[BLINK_SHIFT].
  - DEAD: hp_out=0, dead=1, hit is ignored. start -> ALIVE with hp_out=HP_MAX in the same update.
- Simultaneous events:
  - start+hit in IDLE or DEAD: start wins and the hit is dropped.
  - hit+tick in ALIVE: the hit is processed. The tick does not pre-decrement the freshly loaded inv_cnt.
- A hit on the cycle after INVULN returns to ALIVE is accepted normally.
- Reset mid-INVULN or mid-DEAD returns immediately to the reset values above.
- hp_out never exceeds HP_MAX and never underflows below 0.

Optional Feature:
- Macro: HP_REGEN_EN.
- Defined:
  - In ALIVE only, regen_cnt counts ticks. On reaching REGEN_FRAMES: if hp<HP_MAX then hp+1, and regen_cnt clears in either case.
  - regen_cnt clears on any accepted hit and on entry to ALIVE from IDLE or DEAD.
  - regen_cnt holds its value in INVULN.
  - If a hit and a regen step fall on the same cycle, the hit wins and the regen step is lost.
- Undefined: no regen_cnt logic. HP increases only via start.

Test Plan:
- Bench parameters: INVULN_FRAMES=3, REGEN_FRAMES=4, HP_MAX=9, vblnk pulsing every 20 clk.
- Reset then start; hit dmg=2 -> hp_out 9→7 one cycle later, invuln=1. After exactly 3 ticks, invuln=0 and state is ALIVE.
- During INVULN, hit dmg=5 -> hp_out stays 7. After return to ALIVE, hit dmg=5 -> hp_out=2.
- hp_out=2, hit dmg=15 -> hp_out=0, dead=1. Further hits -> no change. start -> hp_out=9, dead=0, invuln=0.
- In IDLE, hit and start in the same cycle -> state ALIVE, hp_out=9. hit dmg=0 in ALIVE -> no change, invuln stays 0.
- Blink with INVULN_FRAMES=8, BLINK_SHIFT=1 -> blink toggles every 2 ticks. Assert rst mid-INVULN -> hp_out=9, invuln=0, blink=0 without waiting for a clock edge.
- With HP_REGEN_EN: hp_out=7 in ALIVE, no hits -> hp_out=8 after 4 ticks, 9 after 8 ticks, stays 9 after 12 ticks. A hit at tick 3 restarts the count.
